// File: rtl/lif_stimulus_sequencer.sv
// ---------------------------------------------------------------------------
// lif_stimulus_sequencer
//
// Transmit-side companion to the LIF neuron tile. Host bytes (input-spike
// bytes or weight bytes) enter through a valid/ready FIFO. They are replayed
// one per cycle on the neuron's byte-wide load bus. The block also counts the
// neuron's output spikes over fixed windows so a host can read a firing rate.
//
// Ports:
//   clk          rising-edge clock for all state
//   reset        synchronous, active-high; empties the FIFO and restarts
//                the spike window
//   in_valid     host byte offered
//   in_ready     FIFO not full (depends only on FIFO level)
//   in_data      host byte
//   in_weight    1 = weight byte, 0 = input-spike byte
//   tx_pause     1 = hold the FIFO and drive idle on the tx bus
//   tx_data      registered byte to the neuron load bus
//   tx_weight    registered weight-select to the neuron
//   tx_valid     registered; 1 = tx_data is a popped FIFO entry
//   spike_in     neuron spike output, sampled every cycle
//   spike_count  spikes seen in the last completed window
//   count_valid  one-cycle pulse when spike_count updates
//   fifo_level   current FIFO occupancy
// ---------------------------------------------------------------------------
module lif_stimulus_sequencer #(
    parameter int DEPTH  = 8,
    parameter int WINDOW = 16,
    parameter int CW     = $clog2(WINDOW + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    input  logic                     in_weight,
    input  logic                     tx_pause,
    output logic [7:0]               tx_data,
    output logic                     tx_weight,
    output logic                     tx_valid,
    input  logic                     spike_in,
    output logic [CW-1:0]            spike_count,
    output logic                     count_valid,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(WINDOW);

    // FIFO storage and pointers. Each pointer has one extra wrap bit, so
    // full and empty can be told apart when the low bits are equal.
    logic [8:0]  mem_q [DEPTH];
    logic [8:0]  mem_d [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_weight_q, tx_weight_d;
    logic        tx_valid_q, tx_valid_d;

    logic [WW-1:0] win_cnt_q, win_cnt_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [CW-1:0] spike_count_q, spike_count_d;
    logic          count_valid_q, count_valid_d;

    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        win_last;
    logic [8:0]  head;

    // Full blocks a push even if a pop happens on the same edge.
    // There is no bypass path around a full FIFO.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push     = in_valid && !full;
    assign pop      = !empty && !tx_pause;
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign win_last = (win_cnt_q == WW'(WINDOW - 1));

    assign in_ready    = !full;
    assign fifo_level  = wr_ptr_q - rd_ptr_q;
    assign tx_data     = tx_data_q;
    assign tx_weight   = tx_weight_q;
    assign tx_valid    = tx_valid_q;
    assign spike_count = spike_count_q;
    assign count_valid = count_valid_q;

    // FIFO write and pointer advance. Entries hold {weight, data}.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = {in_weight, in_data};
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // The transmitter shows the popped head for exactly one cycle. Otherwise
    // it drives the idle byte 0x00 with select 0, which the neuron treats as
    // "no input spikes", so the neuron only leaks.
    always_comb begin
        tx_data_d   = 8'h00;
        tx_weight_d = 1'b0;
        tx_valid_d  = 1'b0;
        if (pop) begin
            tx_data_d   = head[7:0];
            tx_weight_d = head[8];
            tx_valid_d  = 1'b1;
        end
    end

    // Free-running spike window. A spike on the window's last cycle is
    // folded into that window's result, not the next window's.
    always_comb begin
        win_cnt_d     = win_cnt_q + {{(WW-1){1'b0}}, 1'b1};
        acc_d         = acc_q + {{(CW-1){1'b0}}, spike_in};
        spike_count_d = spike_count_q;
        count_valid_d = 1'b0;
        if (win_last) begin
            win_cnt_d     = '0;
            acc_d         = '0;
            spike_count_d = acc_q + {{(CW-1){1'b0}}, spike_in};
            count_valid_d = 1'b1;
        end
    end

    // Storage array has no reset; the pointers alone decide which entries
    // are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state. Reset wins over everything and drops any in-flight byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tx_data_q     <= 8'h00;
            tx_weight_q   <= 1'b0;
            tx_valid_q    <= 1'b0;
            win_cnt_q     <= '0;
            acc_q         <= '0;
            spike_count_q <= '0;
            count_valid_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tx_data_q     <= tx_data_d;
            tx_weight_q   <= tx_weight_d;
            tx_valid_q    <= tx_valid_d;
            win_cnt_q     <= win_cnt_d;
            acc_q         <= acc_d;
            spike_count_q <= spike_count_d;
            count_valid_q <= count_valid_d;
        end
    end

endmodule

// File: tb/tb_lif_stimulus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lif_stimulus_sequencer
//
// Directed bench for lif_stimulus_sequencer with DEPTH=8 and WINDOW=16.
// Inputs change on the falling edge. A queue-based model advances right after
// each rising edge, and the outputs are compared on every falling edge.
// Hand-computed literal checks at key points keep the model honest.
// ---------------------------------------------------------------------------
module tb_lif_stimulus_sequencer;

    localparam int DEPTH  = 8;
    localparam int WINDOW = 16;
    localparam int CW     = $clog2(WINDOW + 1);

    logic                   clk;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [7:0]             in_data;
    logic                   in_weight;
    logic                   tx_pause;
    logic [7:0]             tx_data;
    logic                   tx_weight;
    logic                   tx_valid;
    logic                   spike_in;
    logic [CW-1:0]          spike_count;
    logic                   count_valid;
    logic [$clog2(DEPTH):0] fifo_level;

    int vectors;
    int miscompares;

    // Model state: the queue holds {weight, data} in push order.
    logic [8:0] exp_q[$];
    int         exp_tx_data;
    int         exp_tx_weight;
    int         exp_tx_valid;
    int         exp_count;
    int         exp_cv;
    int         spike_sum;
    int         edges_since_reset;
    bit         model_valid;

    lif_stimulus_sequencer #(.DEPTH(DEPTH), .WINDOW(WINDOW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_weight   (in_weight),
        .tx_pause    (tx_pause),
        .tx_data     (tx_data),
        .tx_weight   (tx_weight),
        .tx_valid    (tx_valid),
        .spike_in    (spike_in),
        .spike_count (spike_count),
        .count_valid (count_valid),
        .fifo_level  (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one value and logs any mismatch.
    task automatic checkVal(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares every DUT output against the model.
    task automatic checkOutput();
        checkVal("tx_data",     int'(tx_data),     exp_tx_data);
        checkVal("tx_weight",   int'(tx_weight),   exp_tx_weight);
        checkVal("tx_valid",    int'(tx_valid),    exp_tx_valid);
        checkVal("spike_count", int'(spike_count), exp_count);
        checkVal("count_valid", int'(count_valid), exp_cv);
        checkVal("fifo_level",  int'(fifo_level),  exp_q.size());
        checkVal("in_ready",    int'(in_ready),    (exp_q.size() < DEPTH) ? 1 : 0);
    endtask

    // Models one rising edge from the inputs the bench is driving.
    task automatic modelEdge();
        bit can_push;
        logic [8:0] e;
        if (reset) begin
            exp_q.delete();
            exp_tx_data = 0; exp_tx_weight = 0; exp_tx_valid = 0;
            exp_count = 0; exp_cv = 0; spike_sum = 0; edges_since_reset = 0;
            model_valid = 1'b1;
        end else begin
            can_push = (exp_q.size() < DEPTH);
            if (exp_q.size() > 0 && !tx_pause) begin
                e = exp_q.pop_front();
                exp_tx_data = int'(e[7:0]); exp_tx_weight = int'(e[8]); exp_tx_valid = 1;
            end else begin
                exp_tx_data = 0; exp_tx_weight = 0; exp_tx_valid = 0;
            end
            if (in_valid && can_push) exp_q.push_back({in_weight, in_data});
            spike_sum += int'(spike_in);
            edges_since_reset++;
            if (edges_since_reset % WINDOW == 0) begin
                exp_count = spike_sum; spike_sum = 0; exp_cv = 1;
            end else begin
                exp_cv = 0;
            end
        end
    endtask

    // Drives one cycle of inputs, then returns at the following falling edge.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic w,
                                 input logic p, input logic s);
        in_valid = v; in_data = d; in_weight = w; tx_pause = p; spike_in = s;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (model_valid) checkOutput();
    end

    initial begin
        vectors = 0; miscompares = 0; model_valid = 1'b0;
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_weight = 1'b0;
        tx_pause = 1'b0; spike_in = 1'b0;
        @(negedge clk);
        applyReset();
        checkVal("reset_level", int'(fifo_level), 0);
        checkVal("reset_ready", int'(in_ready), 1);
        checkVal("reset_txv",   int'(tx_valid), 0);

        // Single byte: push at edge 1, visible after edge 2 for one cycle.
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkVal("single_data", int'(tx_data), 32'hA5);
        checkVal("single_txv",  int'(tx_valid), 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkVal("single_idle", int'(tx_valid), 0);

        // Burst into a paused FIFO: only 8 of 10 are accepted.
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 8'(i + 1), 1'b0, 1'b1, 1'b0);
        checkVal("full_level", int'(fifo_level), 8);
        checkVal("full_ready", int'(in_ready), 0);
        for (int j = 0; j < 8; j++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            checkVal("drain_data",  int'(tx_data), j + 1);
            checkVal("drain_level", int'(fifo_level), 7 - j);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkVal("drain_idle", int'(tx_valid), 0);

        // Alternating weight/input stream with simultaneous push and pop.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, (i % 2 == 0) ? 8'hFF : 8'h3C, (i % 2 == 0), 1'b0, 1'b0);
            if (i >= 1) begin
                checkVal("mix_level",  int'(fifo_level), 1);
                checkVal("mix_data",   int'(tx_data), (i % 2 == 1) ? 32'hFF : 32'h3C);
                checkVal("mix_weight", int'(tx_weight), (i % 2 == 1) ? 1 : 0);
            end
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Pause mid-burst: the head is retained across the pause.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 8'(8'h11 + i), 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkVal("pause_pop2", int'(tx_data), 32'h12);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            checkVal("pause_txv",   int'(tx_valid), 0);
            checkVal("pause_level", int'(fifo_level), 2);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkVal("resume_3rd", int'(tx_data), 32'h13);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkVal("resume_4th", int'(tx_data), 32'h14);

        // Spike windows aligned to a fresh reset.
        applyReset();
        for (int i = 0; i < WINDOW; i++)
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, (i == 0 || i == 3 || i == 15));
        checkVal("win1_cv",    int'(count_valid), 1);
        checkVal("win1_count", int'(spike_count), 3);
        for (int i = 0; i < WINDOW; i++)
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkVal("win2_count", int'(spike_count), 16);

        // Reset mid-operation drops the in-flight byte and restarts the window.
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkVal("pre_rst_level", int'(fifo_level), 5);
        checkVal("pre_rst_txv",   int'(tx_valid), 1);
        applyReset();
        checkVal("rst_level", int'(fifo_level), 0);
        checkVal("rst_ready", int'(in_ready), 1);
        checkVal("rst_txv",   int'(tx_valid), 0);
        checkVal("rst_count", int'(spike_count), 0);
        for (int i = 0; i < WINDOW - 1; i++)
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkVal("rst_win_early", int'(count_valid), 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkVal("rst_win_pulse", int'(count_valid), 1);
        checkVal("rst_win_count", int'(spike_count), 16);

        // Mixed traffic, pauses and spikes, checked only by the model.
        for (int i = 0; i < 60; i++)
            applyStimulus((i % 3) != 2, 8'(i * 37), (i % 5) == 1, (i % 7) < 2, (i % 4) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lif_stimulus_sequencer.md
# lif_stimulus_sequencer

Transmit-side companion to the LIF neuron tile. It accepts host bytes (input-spike bytes or weight bytes) through a valid/ready FIFO and replays them one per cycle on the neuron's byte-wide load bus (data byte plus weight-select line). It also closes the loop by counting the neuron's output spikes over fixed windows, so a host can measure firing rate without per-cycle sampling.

## Interface
Parameters:
- DEPTH, 8: FIFO depth in entries; power of two, at least 2.
- WINDOW, 16: spike-count window length in cycles; at least 2.
- CW, $clog2(WINDOW+1): spike count width, derived; never overflows.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  host byte offered.
- in_ready  out  1  = !full; combinational from FIFO level only.
- in_data  in  8  host byte.
- in_weight  in  1  1 = weight byte, 0 = input-spike byte.
- tx_pause  in  1  1 = hold FIFO, drive idle on tx.
- tx_data  out  8  byte to the neuron load bus (registered).
- tx_weight  out  1  weight-select to the neuron (registered).
- tx_valid  out  1  1 = tx_data is a popped FIFO entry (registered).
- spike_in  in  1  neuron spike output, sampled every cycle.
- spike_count  out  CW  spikes in the last completed window (registered).
- count_valid  out  1  one-cycle pulse when spike_count updates.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- FIFO: DEPTH entries of {in_weight, in_data}. Read/write pointers are $clog2(DEPTH)+1 bits wide, with wrap bit. Empty when the pointers are equal. Full when the low bits are equal and the wrap bits differ.
- Push: occurs on an edge where in_valid && in_ready.
- Pop: occurs on an edge where !empty && !tx_pause.
- Simultaneous push and pop: both are allowed when not full, and the level is unchanged.
- When full, in_ready = 0 even if a pop happens in the same cycle. There is no full-bypass.
- Transmitter:
  - On a pop edge: tx_data/tx_weight <= head entry, tx_valid <= 1.
  - On any other edge (empty or paused): tx_data <= 0, tx_weight <= 0, tx_valid <= 0.
  - The idle byte 0x00 with select 0 presents "no input spikes" to the neuron, so the neuron leaks only.
- Spike counter:
  - win_cnt runs 0..WINDOW-1 and wraps to 0. It starts after reset and is unaffected by tx_pause or the FIFO.
  - acc increments each edge where spike_in = 1.
  - On the edge where win_cnt = WINDOW-1: spike_count <= acc + spike_in, acc <= 0, count_valid <= 1.
  - count_valid is 0 on all other edges.
- Reset (synchronous, takes priority over everything):
  - Pointers 0, so the FIFO is emptied and pending entries are discarded.
  - tx_data 0, tx_weight 0, tx_valid 0.
  - win_cnt 0, acc 0, spike_count 0, count_valid 0.
  - Consequences: fifo_level 0, in_ready 1. Reset mid-transfer drops the in-flight byte; tx shows idle from the next cycle.

## Timing
- Push-to-tx latency: a byte pushed at edge k, into an empty unpaused FIFO, is popped at edge k+1. It is visible on tx during the cycle after edge k+1, for exactly one cycle.
- Back-to-back: N queued bytes come out on N consecutive cycles with tx_valid held high. Order is strictly FIFO, with weight and input bytes interleaved exactly as pushed.
- tx_pause is sampled each edge. It takes effect on the very next tx update with no drain, and the head entry is retained.
- fifo_level and in_ready reflect pointer state after the most recent edge.
- count_valid first pulses WINDOW edges after reset release, then every WINDOW cycles.
- A spike on the window's last cycle is counted in that window, not the next.

## Test plan
- Single byte: after reset, push 0xA5 with weight=0 at edge 1 → cycle after edge 2 shows tx_data=0xA5, tx_weight=0, tx_valid=1. The following cycle shows 0x00/0/0.
- Burst and full: DEPTH=8, push 10 bytes 0x01..0x0A with tx_pause=1 → in_ready drops after 8 accepted and fifo_level=8. Release the pause → tx shows 0x01..0x08 on 8 consecutive cycles, with fifo_level decrementing to 0.
- Mixed select with simultaneous push/pop: stream alternating weight=1 0xFF and weight=0 0x3C at one per cycle → level stays at 1 and tx alternates 0xFF/1 and 0x3C/0 with no gaps.
- Spike window: WINDOW=16, spike_in high on cycles 0,3,15 of the first window and constant 1 through the second → count_valid pulses, spike_count=3, then spike_count=16.
- Reset mid-operation: FIFO at level 5 and tx_valid=1, assert reset for one edge → next cycle fifo_level=0, in_ready=1, tx 0/0/0, spike_count=0. Window timing restarts.
- Pause mid-burst: 4 queued, pause after 2 pops → tx idle while paused, level stays 2. Resume → 3rd and 4th bytes are output in order.
